conv_kernel_loader: RTL



---
 rtl/conv_ctrl_pkg.sv | 21 ++
 rtl/unit_sel_dec.sv | 23 ++
 rtl/conv_kernel_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
// Purpose: shared types and helpers for the convolution-array control blocks.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SWAP = 2'd2
    } kl_state_t;

    // Kernel bank select encoding carried on cmd_bank.
    localparam logic BANK1 = 1'b0;
    localparam logic BANK2 = 1'b1;

    // Number of weight words in one kernel: edge * edge * depth.
    function automatic int kern_words(input int kern_sz, input int img_d);
        return kern_sz * kern_sz * img_d;
    endfunction

endpackage

// File: rtl/unit_sel_dec.sv
// Purpose: decode a unit index (or broadcast) into a per-unit select vector.
// Latency: combinational.
// Backpressure: none; output follows inputs.
// Ports: unit/bcast/en in, sel[Y] out (one-hot on unit, all-ones on bcast, zero when en=0).
module unit_sel_dec #(
    parameter int Y   = 480,
    parameter int U_W = $clog2(Y)
) (
    input  logic [U_W-1:0] unit,
    input  logic           bcast,
    input  logic           en,
    output logic [Y-1:0]   sel
);

    // Per-bit compare rather than a shift so an out-of-range unit yields all zeros.
    always_comb begin
        sel = '0;
        for (int i = 0; i < Y; i++) begin
            sel[i] = en & (bcast | (unit == U_W'(i)));
        end
    end

endmodule

// File: rtl/conv_kernel_loader.sv
// Purpose: load one kernel (KERN_SZ*KERN_SZ*IMG_D words) into a unit's kernel BRAM bank, then pulse the swap.
// Latency: command->wr_ready 1 cycle; word->BRAM write 1 cycle; last word->ld_new_kernel/done 2 cycles.
// Backpressure: cmd_ready only in IDLE, wr_ready only in LOAD; wr_valid stalls hold the counter; ce=0 freezes all.
// Ports: clk/rst/ce; cmd_valid/cmd_ready/cmd_unit/cmd_bcast/cmd_bank command in; wr_valid/wr_ready/wr_data
//        weight stream in; krnl_wraddr/krnl_wrdata/krnl_bram1_wren/krnl_bram2_wren BRAM write out;
//        ld_new_kernel/done/cmd_err pulses and busy status out.
module conv_kernel_loader
    import conv_ctrl_pkg::*;
#(
    parameter int KERN_SZ = 3,
    parameter int IMG_D   = 6,
    parameter int A_W     = 14,
    parameter int M_W     = 18,
    parameter int Y       = 480,
    parameter int U_W     = $clog2(Y)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [U_W-1:0] cmd_unit,
    input  logic           cmd_bcast,
    input  logic           cmd_bank,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [M_W-1:0] wr_data,
    output logic [A_W-1:0] krnl_wraddr,
    output logic [M_W-1:0] krnl_wrdata,
    output logic [Y-1:0]   krnl_bram1_wren,
    output logic [Y-1:0]   krnl_bram2_wren,
    output logic [Y-1:0]   ld_new_kernel,
    output logic           busy,
    output logic           done,
    output logic           cmd_err
);

    localparam int NW = kern_words(KERN_SZ, IMG_D);
    localparam int CW = $clog2(NW + 1);
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    if (NW > (2 ** A_W)) begin : g_nw_chk
        $error("conv_kernel_loader: kernel does not fit the BRAM address space");
    end

    kl_state_t      state;
    logic [CW-1:0]  count;
    logic [U_W-1:0] lat_unit;
    logic           lat_bcast;
    logic           lat_bank;

    logic [A_W-1:0] wraddr_q;
    logic [M_W-1:0] wrdata_q;
    logic [Y-1:0]   wren1_q;
    logic [Y-1:0]   wren2_q;
    logic [Y-1:0]   ld_q;
    logic           done_q;
    logic           err_q;

    logic [Y-1:0]   sel;
    logic           unit_ok;

    assign unit_ok = {1'b0, cmd_unit} < (U_W + 1)'(Y);

    unit_sel_dec #(
        .Y   (Y),
        .U_W (U_W)
    ) u_sel (
        .unit  (lat_unit),
        .bcast (lat_bcast),
        .en    (state != IDLE),
        .sel   (sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            lat_unit  <= '0;
            lat_bcast <= 1'b0;
            lat_bank  <= BANK1;
            wraddr_q  <= '0;
            wrdata_q  <= '0;
            wren1_q   <= '0;
            wren2_q   <= '0;
            ld_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (ce) begin
            // Pulses clear on every enabled edge; with ce low they hold and
            // are masked at the port, so each one is seen exactly once.
            wren1_q <= '0;
            wren2_q <= '0;
            ld_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_bcast && !unit_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            lat_unit  <= cmd_unit;
                            lat_bcast <= cmd_bcast;
                            lat_bank  <= cmd_bank;
                            count     <= '0;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (wr_valid) begin
                        wraddr_q <= A_W'(count);
                        wrdata_q <= wr_data;
                        wren1_q  <= (lat_bank == BANK1) ? sel : '0;
                        wren2_q  <= (lat_bank == BANK2) ? sel : '0;
                        count    <= count + 1'b1;
                        if (count == LAST) begin
                            state <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    ld_q   <= sel;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready       = ce & ~rst & (state == IDLE);
    assign wr_ready        = ce & ~rst & (state == LOAD);
    assign busy            = (state != IDLE);
    assign krnl_wraddr     = wraddr_q;
    assign krnl_wrdata     = wrdata_q;
    assign krnl_bram1_wren = ce ? wren1_q : '0;
    assign krnl_bram2_wren = ce ? wren2_q : '0;
    assign ld_new_kernel   = ce ? ld_q : '0;
    assign done            = ce & done_q;
    assign cmd_err         = ce & err_q;

endmodule
